// File: rtl/period_meter.sv
// Period / high-time meter for a slow asynchronous square wave, measured in clk cycles.
// Publishes a period/high_time pair on every rising edge and flags loss of signal.
module period_meter #(
    parameter int          W       = 16,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         locked,
    output logic         timeout
);
    typedef enum logic [1:0] {WAIT_FIRST, MEASURE, LOST} state_t;

    state_t       state_q, state_d;
    logic         s1_q, s2_q, s3_q;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] hcnt_q, hcnt_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] high_q, high_d;
    logic         valid_q, valid_d;
    logic         locked_q, locked_d;
    logic         timeout_q, timeout_d;
    logic         rise;

    assign rise = s2_q & ~s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_FIRST;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= sig_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        case (state_q)
            WAIT_FIRST: begin
                if (rise) begin
                    cnt_d   = W'(1);
                    hcnt_d  = W'(1);
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                // A rise on the timeout edge still counts as a measurement.
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                    valid_d  = 1'b1;
                    locked_d = 1'b1;
                    cnt_d    = W'(1);
                    hcnt_d   = W'(1);
                end else if (cnt_q == W'(TIMEOUT)) begin
                    state_d   = LOST;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + W'(1);
                    if (s2_q) hcnt_d = hcnt_q + W'(1);
                end
            end
            LOST: begin
                // First period after loss is discarded: reload only, no valid.
                if (rise) begin
                    cnt_d     = W'(1);
                    hcnt_d    = W'(1);
                    timeout_d = 1'b0;
                    state_d   = MEASURE;
                end
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: two instances (TIMEOUT 200 and 100) share one stimulus.
module tb_period_meter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig_in = 1'b0;
    logic [15:0] pa, ha, pb, hb;
    logic        va, la, ta, vb, lb, tb;

    always #5 clk = ~clk;

    period_meter #(.W(16), .TIMEOUT(200)) dut_a (
        .clk(clk), .rst(rst), .sig_in(sig_in), .period(pa), .high_time(ha),
        .valid(va), .locked(la), .timeout(ta)
    );
    period_meter #(.W(16), .TIMEOUT(100)) dut_b (
        .clk(clk), .rst(rst), .sig_in(sig_in), .period(pb), .high_time(hb),
        .valid(vb), .locked(lb), .timeout(tb)
    );

    int total = 0, bad = 0;
    int cyc = 0;
    int nva, nvb, vbad_a, vbad_b, dbl_a, gapbad_a, lastv_a, ta_cyc, tb_seen;
    int exp_p, exp_h, exp_gap;
    logic prev_va;

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clr();
        nva = 0; nvb = 0; vbad_a = 0; vbad_b = 0; dbl_a = 0; gapbad_a = 0;
        lastv_a = 0; ta_cyc = -1; tb_seen = 0; prev_va = 1'b0;
    endtask

    // Sample outputs settled after the last posedge, then drive the next posedge's inputs.
    task automatic tick(input logic v, input logic r);
        @(negedge clk);
        cyc++;
        if (va) begin
            nva++;
            if (int'(pa) != exp_p || int'(ha) != exp_h) vbad_a++;
            if (prev_va) dbl_a++;
            if (exp_gap != 0 && nva > 1 && (cyc - lastv_a) != exp_gap) gapbad_a++;
            lastv_a = cyc;
        end
        prev_va = va;
        if (vb) begin
            nvb++;
            if (int'(pb) != exp_p || int'(hb) != exp_h) vbad_b++;
        end
        if (ta && ta_cyc < 0) ta_cyc = cyc;
        if (tb) tb_seen = 1;
        sig_in = v;
        rst    = r;
    endtask

    task automatic wave(input int p, input int h, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < p; i++) tick(i < h, 1'b0);
    endtask

    task automatic do_reset();
        repeat (3) tick(1'b0, 1'b1);
        clr();
    endtask

    initial begin
        clr();
        exp_p = 0; exp_h = 0; exp_gap = 0;

        // Reset state
        do_reset();
        chk("rst_period", int'(pa), 0);
        chk("rst_high", int'(ha), 0);
        chk("rst_valid", int'(va), 0);
        chk("rst_locked", int'(la), 0);
        chk("rst_timeout", int'(ta), 0);

        // 50% duty, period 100
        exp_p = 100; exp_h = 50; exp_gap = 100;
        wave(100, 50, 1);
        chk("sq_first_novalid", nva, 0);
        chk("sq_first_unlocked", int'(la), 0);
        wave(100, 50, 3);
        chk("sq_nvalid", nva, 3);
        chk("sq_vals", vbad_a, 0);
        chk("sq_gap", gapbad_a, 0);
        chk("sq_locked", int'(la), 1);
        chk("sq_period", int'(pa), 100);
        chk("sq_high", int'(ha), 50);
        chk("bnd_b_nvalid", nvb, 3);
        chk("bnd_b_vals", vbad_b, 0);
        chk("bnd_b_no_timeout", tb_seen, 0);

        // Asymmetric duty 37/5
        do_reset();
        exp_p = 37; exp_h = 5; exp_gap = 37;
        wave(37, 5, 5);
        chk("asym_nvalid", nva, 4);
        chk("asym_vals", vbad_a, 0);
        chk("asym_gap", gapbad_a, 0);
        chk("asym_width", dbl_a, 0);
        chk("asym_period", int'(pa), 37);
        chk("asym_high", int'(ha), 5);

        // Timeout (200) and recovery
        do_reset();
        exp_p = 100; exp_h = 50; exp_gap = 0;
        wave(100, 50, 3);
        chk("to_nvalid", nva, 2);
        chk("to_pre_locked", int'(la), 1);
        repeat (250) tick(1'b0, 1'b0);
        chk("to_timeout", int'(ta), 1);
        chk("to_unlocked", int'(la), 0);
        chk("to_delay", ta_cyc - lastv_a, 200);
        chk("to_period_hold", int'(pa), 100);
        chk("to_high_hold", int'(ha), 50);
        exp_p = 60; exp_h = 30;
        wave(60, 30, 1);
        chk("rec_timeout_clr", int'(ta), 0);
        chk("rec_no_valid", nva, 2);
        chk("rec_unlocked", int'(la), 0);
        wave(60, 30, 2);
        chk("rec_nvalid", nva, 4);
        chk("rec_vals", vbad_a, 0);
        chk("rec_period", int'(pa), 60);
        chk("rec_locked", int'(la), 1);

        // Boundary: period 101 against TIMEOUT 100
        do_reset();
        exp_p = 101; exp_h = 50; exp_gap = 101;
        wave(101, 50, 3);
        chk("bnd101_b_nvalid", nvb, 0);
        chk("bnd101_b_timeout", tb_seen, 1);
        chk("bnd101_b_period", int'(pb), 0);
        chk("bnd101_a_nvalid", nva, 2);
        chk("bnd101_a_vals", vbad_a, 0);

        // Reset coincident with a registered rise, sig_in held high through reset
        do_reset();
        exp_p = 37; exp_h = 5; exp_gap = 37;
        wave(37, 5, 3);
        chk("mr_pre_locked", int'(la), 1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("mr_period", int'(pa), 0);
        chk("mr_high", int'(ha), 0);
        chk("mr_valid", int'(va), 0);
        chk("mr_locked", int'(la), 0);
        chk("mr_timeout", int'(ta), 0);
        tick(1'b1, 1'b1);
        clr();
        wave(37, 5, 1);
        chk("hi_first_novalid", nva, 0);
        wave(37, 5, 2);
        chk("hi_nvalid", nva, 2);
        chk("hi_vals", vbad_a, 0);
        chk("hi_gap", gapbad_a, 0);

        // Minimum period 2/1
        do_reset();
        exp_p = 2; exp_h = 1; exp_gap = 2;
        wave(2, 1, 6);
        repeat (3) tick(1'b0, 1'b0);
        chk("min_nvalid", nva, 5);
        chk("min_vals", vbad_a, 0);
        chk("min_gap", gapbad_a, 0);
        chk("min_width", dbl_a, 0);
        chk("min_period", int'(pa), 2);
        chk("min_high", int'(ha), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
